// File: rtl/hazard_manager.sv
// Hazard unit for the five-stage MIPS pipeline: RAW forwarding selects, load-use and
// branch-operand bubbles, a data-memory wait/timeout FSM and saturating perf counters.
module hazard_manager #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [4:0]       rs_E,
  input  logic [4:0]       rt_E,
  input  logic [4:0]       dst_E,
  input  logic [4:0]       dst_M,
  input  logic [4:0]       dst_W,
  input  logic             wriSigEXEC,
  input  logic             wriSigMEMO,
  input  logic             wriSigWRIT,
  input  logic             wriRegFromMemEXEC,
  input  logic             wriRegFromMemMEMO,
  input  logic             wriMemorySigEXEC,
  input  logic             wriMemorySigMEMO,
  input  logic             BEQBNE,
  input  logic             JR,
  input  logic             memReady,
  output logic             stall,
  output logic             stop,
  output logic             fwdA_D,
  output logic             fwdB_D,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             memFault,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] stopCount
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;

  localparam logic [15:0]      LP_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CMAX = {CNT_W{1'b1}};

  state_t      r_state, w_next;
  logic [15:0] r_waitCnt, w_waitCnt;
  logic        w_memReq, w_memWait, w_loadUse, w_branch, w_memAlu;

  // $zero is never a real producer, so it never forwards or stalls.
  function automatic logic hit(input logic [4:0] s, input logic [4:0] d, input logic w);
    return w && (d != 5'd0) && (d == s);
  endfunction

  // A LW in MEMORY has no value yet, so its ALU-result path must not be forwarded.
  assign w_memAlu = wriSigMEMO && !wriRegFromMemMEMO;

  always_comb begin
    fwdA_E = 2'd0;
    fwdB_E = 2'd0;
    if (hit(rs_E, dst_M, w_memAlu))        fwdA_E = 2'd2;
    else if (hit(rs_E, dst_W, wriSigWRIT)) fwdA_E = 2'd1;
    if (hit(rt_E, dst_M, w_memAlu))        fwdB_E = 2'd2;
    else if (hit(rt_E, dst_W, wriSigWRIT)) fwdB_E = 2'd1;
  end

  assign fwdA_D = hit(rs_D, dst_M, w_memAlu);
  assign fwdB_D = hit(rt_D, dst_M, w_memAlu);

  assign w_loadUse = wriRegFromMemEXEC &&
                     (hit(rs_D, dst_E, 1'b1) || hit(rt_D, dst_E, 1'b1));

  assign w_branch = (BEQBNE || JR) &&
                    (hit(rs_D, dst_E, wriSigEXEC) || hit(rs_D, dst_M, wriRegFromMemMEMO) ||
                     (BEQBNE && (hit(rt_D, dst_E, wriSigEXEC) ||
                                 hit(rt_D, dst_M, wriRegFromMemMEMO))));

  assign w_memReq  = wriMemorySigMEMO || wriRegFromMemMEMO;
  assign w_memWait = w_memReq && !memReady;

  assign stop     = w_memWait || (r_state == S_FAULT);
  assign stall    = (w_loadUse || w_branch) && !stop;
  assign memFault = (r_state == S_FAULT);

  always_comb begin
    w_next    = r_state;
    w_waitCnt = r_waitCnt;
    case (r_state)
      S_IDLE:
        if (w_memWait) begin
          w_next    = S_WAIT;
          w_waitCnt = 16'd1;
        end
      S_WAIT:
        if (memReady) begin
          w_next    = S_IDLE;
          w_waitCnt = 16'd0;
        end else if (r_waitCnt == LP_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_waitCnt = r_waitCnt + 16'd1;
        end
      default: w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_waitCnt  <= 16'd0;
      stallCount <= '0;
      stopCount  <= '0;
    end else begin
      r_state   <= w_next;
      r_waitCnt <= w_waitCnt;
      if (stall && stallCount != LP_CMAX) stallCount <= stallCount + 1'b1;
      if (stop  && stopCount  != LP_CMAX) stopCount  <= stopCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_manager.sv
// Directed bench for hazard_manager with MEM_TIMEOUT=4 and CNT_W=4.
module tb_hazard_manager;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W;
  logic       wriSigEXEC, wriSigMEMO, wriSigWRIT;
  logic       wriRegFromMemEXEC, wriRegFromMemMEMO;
  logic       wriMemorySigEXEC, wriMemorySigMEMO;
  logic       BEQBNE, JR, memReady;
  logic       stall, stop, fwdA_D, fwdB_D, memFault;
  logic [1:0] fwdA_E, fwdB_E;
  logic [3:0] stallCount, stopCount;
  int errors = 0;
  int checks = 0;

  hazard_manager #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .dst_E(dst_E), .dst_M(dst_M), .dst_W(dst_W),
    .wriSigEXEC(wriSigEXEC), .wriSigMEMO(wriSigMEMO), .wriSigWRIT(wriSigWRIT),
    .wriRegFromMemEXEC(wriRegFromMemEXEC), .wriRegFromMemMEMO(wriRegFromMemMEMO),
    .wriMemorySigEXEC(wriMemorySigEXEC), .wriMemorySigMEMO(wriMemorySigMEMO),
    .BEQBNE(BEQBNE), .JR(JR), .memReady(memReady),
    .stall(stall), .stop(stop), .fwdA_D(fwdA_D), .fwdB_D(fwdB_D),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .memFault(memFault),
    .stallCount(stallCount), .stopCount(stopCount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; dst_E = 0; dst_M = 0; dst_W = 0;
    wriSigEXEC = 0; wriSigMEMO = 0; wriSigWRIT = 0;
    wriRegFromMemEXEC = 0; wriRegFromMemMEMO = 0;
    wriMemorySigEXEC = 0; wriMemorySigMEMO = 0;
    BEQBNE = 0; JR = 0; memReady = 1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    tick(); tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %0b want 0", stop); end
    checks++; if (memFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", memFault); end
    checks++; if (stallCount !== 4'd0 || stopCount !== 4'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", stallCount, stopCount); end
    rst = 0;
    tick();
  endtask

  task automatic test_forwarding;
    clear_inputs();
    dst_M = 5; wriSigMEMO = 1; rs_E = 5; #1;
    checks++; if (fwdA_E !== 2'd2) begin errors++; $display("FAIL fwdA_E_mem got %0d want 2", fwdA_E); end
    dst_W = 5; wriSigWRIT = 1; rt_E = 5; #1;
    checks++; if (fwdA_E !== 2'd2) begin errors++; $display("FAIL fwdA_E_prio got %0d want 2", fwdA_E); end
    checks++; if (fwdB_E !== 2'd2) begin errors++; $display("FAIL fwdB_E_prio got %0d want 2", fwdB_E); end
    rs_D = 5; rt_D = 6; #1;
    checks++; if (fwdA_D !== 1'b1 || fwdB_D !== 1'b0) begin errors++; $display("FAIL fwd_D_alu got %0b%0b want 10", fwdA_D, fwdB_D); end
    // LW in MEMORY: no MEMORY forward, WRITEBACK wins for E, nothing for D
    wriRegFromMemMEMO = 1; #1;
    checks++; if (fwdA_E !== 2'd1) begin errors++; $display("FAIL fwdA_E_lw got %0d want 1", fwdA_E); end
    checks++; if (fwdA_D !== 1'b0) begin errors++; $display("FAIL fwdA_D_lw got %0b want 0", fwdA_D); end
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL stop_ready_first got %0b want 0", stop); end
    clear_inputs();
    dst_M = 0; wriSigMEMO = 1; rs_E = 0; dst_W = 0; wriSigWRIT = 1; #1;
    checks++; if (fwdA_E !== 2'd0 || stall !== 1'b0) begin errors++; $display("FAIL zero_guard got fwd=%0d stall=%0b want 0/0", fwdA_E, stall); end
    tick();
    checks++; if (stopCount !== 4'd0) begin errors++; $display("FAIL stopcnt_fwd got %0d want 0", stopCount); end
  endtask

  task automatic test_load_use;
    clear_inputs();
    wriRegFromMemEXEC = 1; dst_E = 7; rt_D = 7; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %0b want 1", stall); end
    tick();
    clear_inputs(); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_bubble got %0b want 0", stall); end
    checks++; if (stallCount !== 4'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", stallCount); end
    tick();
  endtask

  task automatic test_branch;
    clear_inputs();
    BEQBNE = 1; rt_D = 3; dst_E = 3; wriSigEXEC = 1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL beq_rt_alu got %0b want 1", stall); end
    tick();
    BEQBNE = 0; JR = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_ignores_rt got %0b want 0", stall); end
    tick();
    clear_inputs();
    JR = 1; rs_D = 4; dst_M = 4; wriRegFromMemMEMO = 1; #1;
    checks++; if (stall !== 1'b1 || stop !== 1'b0) begin errors++; $display("FAIL jr_lw_mem got stall=%0b stop=%0b want 1/0", stall, stop); end
    tick();
    clear_inputs(); #1;
    checks++; if (stallCount !== 4'd3) begin errors++; $display("FAIL branch_count got %0d want 3", stallCount); end
    tick();
  endtask

  task automatic test_mem_wait;
    for (int a = 0; a < 2; a++) begin
      clear_inputs();
      wriRegFromMemMEMO = 1; dst_M = 2; memReady = 0;
      wriRegFromMemEXEC = 1; dst_E = 9; rs_D = 9;
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++; if (stop !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL memwait_a%0d_c%0d got stop=%0b stall=%0b want 1/0", a, c, stop, stall); end
        tick();
      end
      memReady = 1; #1;
      checks++; if (stop !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL memdone_a%0d got stop=%0b stall=%0b want 0/1", a, stop, stall); end
      tick();
      clear_inputs(); #1;
      checks++; if (memFault !== 1'b0) begin errors++; $display("FAIL memwait_nofault_a%0d got %0b want 0", a, memFault); end
      checks++; if (stopCount !== 4'(3 * (a + 1))) begin errors++; $display("FAIL stopcnt_a%0d got %0d want %0d", a, stopCount, 3 * (a + 1)); end
      checks++; if (stallCount !== 4'(4 + a)) begin errors++; $display("FAIL stallcnt_a%0d got %0d want %0d", a, stallCount, 4 + a); end
      tick();
    end
  endtask

  task automatic test_timeout;
    clear_inputs();
    wriMemorySigMEMO = 1; memReady = 0;
    for (int e = 1; e <= 4; e++) begin
      #1;
      checks++; if (stop !== 1'b1) begin errors++; $display("FAIL timeout_stop_%0d got %0b want 1", e, stop); end
      tick();
      checks++; if (memFault !== (e == 4)) begin errors++; $display("FAIL timeout_fault_edge%0d got %0b want %0b", e, memFault, e == 4); end
    end
    clear_inputs(); #1;
    checks++; if (stop !== 1'b1 || memFault !== 1'b1) begin errors++; $display("FAIL fault_sticky got stop=%0b fault=%0b want 1/1", stop, memFault); end
    tick();
    rst = 1;
    tick();
    rst = 0; #1;
    checks++; if (memFault !== 1'b0 || stop !== 1'b0) begin errors++; $display("FAIL fault_reset got fault=%0b stop=%0b want 0/0", memFault, stop); end
    checks++; if (stallCount !== 4'd0 || stopCount !== 4'd0) begin errors++; $display("FAIL fault_reset_counts got %0d/%0d want 0/0", stallCount, stopCount); end
  endtask

  task automatic test_saturation;
    clear_inputs();
    wriRegFromMemEXEC = 1; dst_E = 12; rs_D = 12;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 9) begin
        checks++; if (stallCount !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d want 10", stallCount); end
      end
    end
    checks++; if (stallCount !== 4'd15) begin errors++; $display("FAIL sat_end got %0d want 15", stallCount); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_manager.md
# hazard_manager

Pipeline hazard manager for the five-stage MIPS core: the consumer of the per-stage write/load/store flags that the pipelined control path emits, and the producer of the `stall` and `stop` signals that control path obeys. It resolves RAW hazards by forwarding-mux selection in DECODE and EXECUTE, and inserts load-use and branch-operand bubbles. It freezes the whole pipeline while a MEMORY-stage access waits on data memory, declaring a sticky memory fault on timeout. It also keeps saturating stall and stop performance counters.

## Interface
- `MEM_TIMEOUT`, 16: consecutive not-ready MEMORY-stage cycles before a memory fault; legal range 2..65535.
- `CNT_W`, 16: width of the performance counters.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs_D`, `rt_D` in 5 each: source registers of the instruction in DECODE.
- `rs_E`, `rt_E` in 5 each: source registers of the instruction in EXECUTE.
- `dst_E`, `dst_M`, `dst_W` in 5 each: destination register in EXECUTE, MEMORY and WRITEBACK.
- `wriSigEXEC`, `wriSigMEMO`, `wriSigWRIT` in 1 each: the instruction in that stage writes the register file.
- `wriRegFromMemEXEC`, `wriRegFromMemMEMO` in 1 each: the instruction in that stage is LW.
- `wriMemorySigEXEC`, `wriMemorySigMEMO` in 1 each: the instruction in that stage is SW.
- `BEQBNE`, `JR` in 1 each: DECODE holds a branch or JR, which reads registers in DECODE.
- `memReady` in 1: data memory completes the current access this cycle.
- `stall` out 1: freeze FETCH/DECODE and inject a bubble into EXECUTE.
- `stop` out 1: freeze all pipeline registers.
- `fwdA_D`, `fwdB_D` out 1 each: DECODE comparator operand selects; 1 = MEMORY-stage ALU result.
- `fwdA_E`, `fwdB_E` out 2 each: ALU operand selects; 0 = register file, 1 = WRITEBACK result, 2 = MEMORY ALU result.
- `memFault` out 1: sticky memory timeout flag.
- `stallCount`, `stopCount` out CNT_W each: saturating event counters.

## Operation
- Define `hit(s, d, w)` = `w && d != 0 && d == s`.
- EXECUTE forwarding (A shown; B uses `rt_E`):
  - `fwdA_E` = 2 if `hit(rs_E, dst_M, wriSigMEMO) && !wriRegFromMemMEMO`.
  - Otherwise `fwdA_E` = 1 if `hit(rs_E, dst_W, wriSigWRIT)`.
  - Otherwise `fwdA_E` = 0. MEMORY has priority over WRITEBACK.
- DECODE forwarding: `fwdA_D` = `hit(rs_D, dst_M, wriSigMEMO) && !wriRegFromMemMEMO`; `fwdB_D` is the same with `rt_D`.
- Load-use hazard: `wriRegFromMemEXEC` and (`hit(rs_D, dst_E, 1)` or `hit(rt_D, dst_E, 1)`).
- Branch hazard: (`BEQBNE || JR`) and either of the following, for `rs_D`, or for `rt_D` when `BEQBNE`:
  - `hit(x, dst_E, wriSigEXEC)`;
  - `hit(x, dst_M, wriRegFromMemMEMO)`.
- `stall` = (load-use or branch hazard) and not `stop`. `stop` has priority; `stall` is never high together with `stop`.
- `memReq` = `wriMemorySigMEMO || wriRegFromMemMEMO`.
- `stop` = (`memReq && !memReady`) or state FAULT.
- FSM states:
  - IDLE → WAIT when `memReq && !memReady`; `waitCnt` set to 1.
  - WAIT, `memReady`=1 → IDLE; `waitCnt` cleared.
  - WAIT, `memReady`=0 and `waitCnt` == MEM_TIMEOUT−1 → FAULT.
  - WAIT, `memReady`=0 otherwise → WAIT; `waitCnt` +1.
  - FAULT: absorbing until `rst`; `memFault` = 1.
- `stallCount` +1 on each cycle `stall`=1; `stopCount` +1 on each cycle `stop`=1. Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- `stall`, `stop`, `fwd*` are combinational from current-cycle inputs and FSM state; zero-cycle latency.
- Load-use: exactly one `stall` cycle per load-use pair.
- Branch dependent on an EXECUTE ALU result: one `stall` cycle, then `fwd*_D`=1.
- Branch dependent on a LW in EXECUTE: two `stall` cycles, then the value is read from the register file after WRITEBACK.
- `memFault` is registered. It rises at the edge ending the MEM_TIMEOUT-th consecutive not-ready cycle of one access.
- `memReady`=1 in that final cycle clears the wait instead; no fault is raised.
- `memReady`=1 on the first cycle of an access: no `stop`, FSM stays IDLE.
- Back-to-back accesses: each new access starts its count from 1 after IDLE.
- Reset values: FSM IDLE, `waitCnt` 0, `memFault` 0, `stallCount` 0, `stopCount` 0.
- During reset: outputs follow the combinational rules with reset state.
- `rst` mid-WAIT or in FAULT returns to IDLE on the next edge.

## Test plan
- ALU back-to-back: `dst_M`=5, `wriSigMEMO`=1, `rs_E`=5 → `fwdA_E`=2. Also `dst_W`=5, `wriSigWRIT`=1 → `fwdA_E` still 2.
- $zero guard: `dst_M`=0, `wriSigMEMO`=1, `rs_E`=0 → `fwdA_E`=0, `stall`=0.
- Load-use: `wriRegFromMemEXEC`=1, `dst_E`=7, `rt_D`=7 → `stall`=1 for exactly 1 cycle, `stallCount`=1.
- Memory wait: `wriRegFromMemMEMO`=1, `memReady` low 3 cycles then high → `stop` high 3 cycles, no `memFault`, `stopCount`=3. A simultaneous load-use hazard keeps `stall`=0 during `stop`.
- Timeout (MEM_TIMEOUT=4): `memReady` held 0 → `memFault`=1 after the 4th edge, `stop` held 1. Pulse `rst` → `memFault`=0, `stop`=0, counters 0.
- Saturation (CNT_W=4): continuous `stall` for 20 cycles → `stallCount` stops at 15.
